// File: rtl/cmmdc_pkg.sv
// Shared definitions for the binary (Stein) GCD unit: FSM state encoding and
// the width helper for the common power-of-two exponent register.
package cmmdc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    LOOP   = 2'd2
  } state_t;

  // The exponent counts shared factors of two, at most WIDTH-1 of them.
  function automatic int k_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/cmmdc_bin_if.sv
// Request/result bundle of the binary GCD unit: start/x/y in, r/ack/busy/err/cyc out.
interface cmmdc_bin_if #(
  parameter int WIDTH = 8,
  parameter int CYC_W = 8
) ();

  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] r;
  logic             ack;
  logic             busy;
  logic             err;
  logic [CYC_W-1:0] cyc;

  modport master (output start, x, y, input r, ack, busy, err, cyc);
  modport slave  (input start, x, y, output r, ack, busy, err, cyc);

endinterface

// File: rtl/cmmdc_bin.sv
// Binary (Stein) GCD: factor out common twos in REDUCE, then shift/subtract in
// LOOP with a kept odd; zero operands finish on the accept edge.
module cmmdc_bin
  import cmmdc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CYC_W = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  cmmdc_bin_if.slave bus
);

  localparam int K_W = k_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [CYC_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] count_inc;

  assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;

  always_comb begin
    // NOTE: every target gets a default first, so no path through the case leaves one unassigned (no latch).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    count_d = count_q;
    r_d     = r_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    err_d   = err_q;
    cyc_d   = cyc_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.x == '0 || bus.y == '0) begin
            r_d   = bus.x | bus.y;
            err_d = (bus.x == '0) && (bus.y == '0);
            cyc_d = '0;
            ack_d = 1'b1;
          end else begin
            a_d     = bus.x;
            b_d     = bus.y;
            k_d     = '0;
            count_d = '0;
            busy_d  = 1'b1;
            state_d = REDUCE;
          end
        end
      end

      REDUCE: begin
        count_d = count_inc;
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + 1'b1;
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else begin
          state_d = LOOP;
        end
      end

      LOOP: begin
        count_d = count_inc;
        if (b_q == '0) begin
          r_d     = a_q << k_q;
          err_d   = 1'b0;
          cyc_d   = count_inc;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q > b_q) begin
          // a stays odd: the smaller odd value moves into a, the even difference into b.
          a_d = b_q;
          b_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (Rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      count_q <= '0;
      r_q     <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      count_q <= count_d;
      r_q     <= r_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
    end
  end

  assign bus.r    = r_q;
  assign bus.ack  = ack_q;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;
  assign bus.cyc  = cyc_q;

endmodule

// File: tb/tb_cmmdc_bin.sv
// Bench for cmmdc_bin: an 8-bit and a 16-bit (narrow, saturating cyc) instance
// checked every cycle against a transaction-level GCD model, plus directed cases.
module tb_cmmdc_bin;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8, rst16;
  logic chk_en = 1'b0;

  cmmdc_bin_if #(.WIDTH(8),  .CYC_W(8)) b8 ();
  cmmdc_bin_if #(.WIDTH(16), .CYC_W(4)) b16 ();

  cmmdc_bin #(.WIDTH(8),  .CYC_W(8)) dut8  (.Clk(clk), .Rst(rst8),  .bus(b8));
  cmmdc_bin #(.WIDTH(16), .CYC_W(4)) dut16 (.Clk(clk), .Rst(rst16), .bus(b16));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stein's algorithm on plain integers; n = clock edges from accept to result.
  function automatic void stein(input int unsigned x, input int unsigned y,
                                output int unsigned g, output int unsigned n);
    int unsigned a = x, b = y, k = 0;
    n = 0;
    while (a % 2 == 0) begin
      n++;
      if (b % 2 == 0) begin a /= 2; b /= 2; k++; end
      else a /= 2;
    end
    n++;
    while (b != 0) begin
      n++;
      if (b % 2 == 0) b /= 2;
      else if (a > b) begin int unsigned t = a - b; a = b; b = t; end
      else b -= a;
    end
    n++;
    g = a << k;
  endfunction

  typedef struct {
    bit          busy;
    int unsigned rem, n, g, r, cyc;
    bit          ack, err;
  } mdl_t;

  function automatic mdl_t model_step(input mdl_t m, input bit rst, input bit start,
                                      input int unsigned x, input int unsigned y,
                                      input int unsigned cmax);
    mdl_t s = m;
    if (rst) begin
      s = '{default: 0};
      return s;
    end
    s.ack = 1'b0;
    if (!m.busy) begin
      if (start) begin
        if (x == 0 || y == 0) begin
          s.r = x | y; s.err = (x == 0 && y == 0); s.cyc = 0; s.ack = 1'b1;
        end else begin
          stein(x, y, s.g, s.n);
          s.rem = s.n; s.busy = 1'b1;
        end
      end
    end else if (m.rem == 1) begin
      s.r = m.g; s.err = 1'b0; s.cyc = (m.n > cmax) ? cmax : m.n;
      s.ack = 1'b1; s.busy = 1'b0;
    end else begin
      s.rem = m.rem - 1;
    end
    return s;
  endfunction

  mdl_t m8 = '{default: 0};
  mdl_t m16 = '{default: 0};

  always @(posedge clk) begin
    m8  <= model_step(m8,  rst8,  b8.start,  b8.x,  b8.y,  255);
    m16 <= model_step(m16, rst16, b16.start, b16.x, b16.y, 15);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("r8",     b8.r,     m8.r);
      check("ack8",   b8.ack,   m8.ack);
      check("busy8",  b8.busy,  m8.busy);
      check("err8",   b8.err,   m8.err);
      check("cyc8",   b8.cyc,   m8.cyc);
      check("r16",    b16.r,    m16.r);
      check("ack16",  b16.ack,  m16.ack);
      check("busy16", b16.busy, m16.busy);
      check("err16",  b16.err,  m16.err);
      check("cyc16",  b16.cyc,  m16.cyc);
    end
  end

  task automatic op8(input logic [7:0] x, input logic [7:0] y,
                     output logic [7:0] r, output logic [7:0] cyc, output logic err,
                     output int busy_cycles, output int lat);
    @(negedge clk);
    b8.x = x; b8.y = y; b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    busy_cycles = 0;
    lat = 0;
    while (!b8.ack && lat < 100) begin
      if (b8.busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    check("op8_timeout", lat < 100, 1);
    r = b8.r; cyc = b8.cyc; err = b8.err;
  endtask

  task automatic op16(input logic [15:0] x, input logic [15:0] y,
                      output logic [15:0] r, output logic [3:0] cyc);
    int t = 0;
    @(negedge clk);
    b16.x = x; b16.y = y; b16.start = 1'b1;
    @(negedge clk);
    b16.start = 1'b0;
    while (!b16.ack && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("op16_timeout", t < 100, 1);
    r = b16.r; cyc = b16.cyc;
  endtask

  initial begin
    logic [7:0]  r8, c8;
    logic [15:0] r16;
    logic [3:0]  c16;
    logic        e8, seen;
    int          bc, lat, nack, last;
    int unsigned g, n;

    b8.start = 0;  b8.x = 0;  b8.y = 0;
    b16.start = 0; b16.x = 0; b16.y = 0;
    rst8 = 1'b1; rst16 = 1'b1;
    repeat (2) @(negedge clk);
    rst8 = 1'b0; rst16 = 1'b0;
    chk_en = 1'b1;

    check("rst_r8", b8.r, 0);
    check("rst_ack8", b8.ack, 0);
    check("rst_busy8", b8.busy, 0);
    check("rst_cyc16", b16.cyc, 0);

    stein(12, 18, g, n);        check("model_12_18_g", g, 6);  check("model_12_18_n", n, 7);
    stein(255, 255, g, n);      check("model_255_g", g, 255);  check("model_255_n", n, 3);
    stein(48000, 36000, g, n);  check("model_48k_g", g, 12000); check("model_48k_n", n, 12);

    op8(8'd12, 8'd18, r8, c8, e8, bc, lat);
    check("gcd_12_18_r", r8, 6); check("gcd_12_18_cyc", c8, 7);
    check("gcd_12_18_err", e8, 0); check("gcd_12_18_busy", bc, 7);

    op8(8'd255, 8'd255, r8, c8, e8, bc, lat);
    check("gcd_255_r", r8, 255); check("gcd_255_cyc", c8, 3); check("gcd_255_err", e8, 0);

    op8(8'd0, 8'd20, r8, c8, e8, bc, lat);
    check("zero_x_r", r8, 20); check("zero_x_cyc", c8, 0); check("zero_x_err", e8, 0);
    check("zero_x_busy", bc, 0); check("zero_x_lat", lat, 0);

    op8(8'd0, 8'd0, r8, c8, e8, bc, lat);
    check("zero_both_r", r8, 0); check("zero_both_err", e8, 1);

    // Abort: reset on the third edge after accept.
    @(negedge clk);
    b8.x = 8'd12; b8.y = 8'd18; b8.start = 1'b1;
    @(negedge clk); b8.start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst8 = 1'b1;
    @(negedge clk); rst8 = 1'b0;
    check("abort_r", b8.r, 0); check("abort_busy", b8.busy, 0); check("abort_ack", b8.ack, 0);
    seen = 1'b0;
    repeat (12) begin @(negedge clk); seen |= b8.ack; end
    check("abort_no_ack", seen, 0);
    op8(8'd9, 8'd6, r8, c8, e8, bc, lat);
    check("after_abort_r", r8, 3);

    // Back-to-back with start held; x is scrambled while busy.
    @(negedge clk);
    b8.x = 8'd12; b8.y = 8'd18; b8.start = 1'b1;
    nack = 0; last = -1;
    for (int i = 0; i < 60 && nack < 4; i++) begin
      @(negedge clk);
      if (b8.ack) begin
        check("b2b_r", b8.r, 6);
        if (last >= 0) check("b2b_period", i - last, 8);
        last = i;
        nack++;
      end
      b8.x = b8.busy ? 8'($urandom) : 8'd12;
    end
    b8.start = 1'b0;
    check("b2b_count", nack, 4);
    repeat (10) @(negedge clk);

    op16(16'd48000, 16'd36000, r16, c16);
    check("w16_48k_r", r16, 12000); check("w16_48k_cyc", c16, 12);
    op16(16'd65535, 16'd1, r16, c16);
    check("w16_max_1_r", r16, 1); check("w16_max_1_cyc_sat", c16, 15);
    op16(16'd32768, 16'd16384, r16, c16);
    check("w16_pow2_r", r16, 16384); check("w16_pow2_cyc_sat", c16, 15);

    // Random traffic on both instances; the per-cycle compare does the checking.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      b8.start  = ($urandom_range(0, 3) != 0);
      b8.x      = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      b8.y      = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      rst8      = ($urandom_range(0, 199) == 0);
      b16.start = ($urandom_range(0, 3) != 0);
      b16.x     = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      b16.y     = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      rst16     = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    b8.start = 1'b0; b16.start = 1'b0; rst8 = 1'b0; rst16 = 1'b0;
    repeat (60) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmmdc_bin.md
Name: cmmdc_bin

Overview:
- Parametrised successor to the subtractive GCD (cmmdc) unit.
- Computes gcd(x, y) for WIDTH-bit unsigned operands using the binary (Stein) algorithm: shifts plus one subtract per cycle.
- Adds explicit zero-operand handling, a busy flag and an iteration count for performance checks.
- Sits behind the same start/ack handshake as the existing arithmetic blocks and is driven by the common Clk.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- CYC_W, 8, width of the iteration-count output; the count saturates at all-ones.
- K_W, $clog2(WIDTH)+1, width of the common power-of-two exponent register (localparam, derived).

Ports:
- Clk  input  1  system clock, all state updates on posedge.
- Rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- x  input  WIDTH  operand A; sampled on the accept edge.
- y  input  WIDTH  operand B; sampled on the accept edge.
- r  output  WIDTH  result register; holds its value until the next completion.
- ack  output  1  one-cycle completion pulse, registered with r.
- busy  output  1  high from the accept edge until the completion edge.
- err  output  1  set on completion when x==0 and y==0; otherwise cleared on completion.
- cyc  output  CYC_W  clock edges from accept to completion, excluding the accept edge.

Behaviour:
- Reset (Rst=1 at posedge, overrides everything):
  - state=IDLE; r=0, ack=0, busy=0, err=0, cyc=0.
  - Internal a, b, k and count are cleared.
  - Reset mid-operation aborts the computation; no ack is produced.
- ack defaults to 0 every cycle unless set by a completion edge.
- IDLE:
  - start=0: no change.
  - start=1 and (x==0 or y==0): immediate completion on the same edge. r<=x|y; err<=(x==0 && y==0); cyc<=0; ack<=1; stay in IDLE; busy stays 0.
  - start=1, both nonzero: a<=x, b<=y, k<=0, count<=0, busy<=1, state<=REDUCE.
- REDUCE (count increments, saturating):
  - a, b both even: a>>=1, b>>=1, k+=1.
  - else if a even: a>>=1.
  - else (a odd): state<=LOOP, a and b unchanged.
- LOOP (count increments, saturating):
  - b==0: completion. r<=a<<k (truncated to WIDTH; cannot overflow because the result is <= min(x,y)); err<=0; cyc<=count+1 (saturating); ack<=1; busy<=0; state<=IDLE.
  - else if b even: b>>=1.
  - else if a>b: a<=b, b<=a-b (swap combined with subtract; the difference is even).
  - else: b<=b-a.
- Invariant: a is odd in LOOP.
- start while busy is ignored. start on the completion edge is ignored. A new request is accepted at the earliest on the edge after ack rises.
- x/y changes while busy have no effect.
- Worst-case latency is bounded by about 3*WIDTH cycles. The cyc output saturates rather than wrapping.
- Arithmetic is unsigned throughout; no sign handling.

Decomposition:
- Shared package (cmmdc_pkg):
  - state encoding localparams IDLE=0, REDUCE=1, LOOP=2 (2-bit);
  - a function computing K_W from WIDTH.
- No sub-module: a single FSM plus datapath. The iteration counter is inline with saturate logic.
- The clock generator module from the existing bench is reused unchanged for test benches.

Test Plan:
- WIDTH=8, start one cycle with x=12, y=18 -> ack one cycle, r=6, err=0, cyc=7; busy high 7 cycles.
- x=255, y=255 -> r=255, cyc=3, err=0.
- x=0, y=20 -> ack on the accept edge's next cycle, r=20, cyc=0, err=0, busy never high. x=0, y=0 -> r=0, err=1.
- x=12, y=18; assert Rst on the 3rd edge after accept -> no ack, r=0, busy=0. A following request with x=9, y=6 returns r=3.
- start held high continuously with x=12, y=18 -> back-to-back results r=6. Each new accept occurs on the edge after ack, never on the ack edge; changing x mid-computation does not alter r.
- WIDTH=16: x=48000, y=36000 -> r=12000. x=65535, y=1 -> r=1. x=32768, y=16384 -> r=16384 with k=14.
